// File: rtl/mac_dot_seq_if.sv
// rtl/mac_dot_seq_if.sv - operand-pair and result handshake bundle for mac_dot_seq
interface mac_dot_seq_if #(
  parameter int VEC_LEN = 8
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);

  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_a;
  logic [7:0]       s_b;
  logic             s_last;
  logic             r_valid;
  logic             r_ready;
  logic [15:0]      r_data;
  logic [CNT_W-1:0] r_len;

  modport master (
    output s_valid, s_a, s_b, s_last, r_ready,
    input  s_ready, r_valid, r_data, r_len
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last, r_ready,
    output s_ready, r_valid, r_data, r_len
  );
endinterface

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - sequencer feeding vectors of operand pairs to an external MAC
// and returning each dot product (mod 2^16) as a result beat.
module mac_dot_seq #(
  parameter  int VEC_LEN = 8,
  localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic          clk,
  input  logic          sclr,
  mac_dot_seq_if.slave  bus,
  output logic [7:0]    mac_ina,
  output logic [7:0]    mac_inb,
  output logic          mac_sclrn,
  input  logic [15:0]   mac_out
);
  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  assign bus.s_ready = (state == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (sclr) begin
      state       <= ST_CLEAR;
      mac_sclrn   <= 1'b0;
      mac_ina     <= 8'd0;
      mac_inb     <= 8'd0;
      bus.r_valid <= 1'b0;
      bus.r_data  <= 16'd0;
      bus.r_len   <= '0;
      cnt         <= '0;
    end else begin
      // The MAC has no enable: zero operands are what hold its accumulator.
      mac_ina <= 8'd0;
      mac_inb <= 8'd0;
      case (state)
        ST_CLEAR: begin
          mac_sclrn <= 1'b1;
          state     <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (bus.s_valid) begin
            mac_ina <= bus.s_a;
            mac_inb <= bus.s_b;
            cnt     <= cnt + 1'b1;
            if (bus.s_last || cnt == LAST_IDX) begin
              bus.r_len <= cnt + 1'b1;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          bus.r_data  <= mac_out;
          bus.r_valid <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            cnt         <= '0;
            mac_sclrn   <= 1'b0;
            state       <= ST_CLEAR;
          end
        end
        default: begin
          mac_sclrn <= 1'b0;
          state     <= ST_CLEAR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - self-checking bench for mac_dot_seq with a behavioural MAC
module tb_mac_dot_seq;
  localparam int VEC_LEN = 4;
  localparam int CNT_W   = $clog2(VEC_LEN + 1);

  logic        clk = 1'b0;
  logic        sclr;
  logic [7:0]  mac_ina;
  logic [7:0]  mac_inb;
  logic        mac_sclrn;
  logic [15:0] acc;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;
  int exp_results = 0;
  bit mon_en = 1'b0;

  logic [7:0] va [VEC_LEN];
  logic [7:0] vb [VEC_LEN];

  typedef struct {
    string       name;
    int          n;
    bit          use_last;
    int          gap;
    int          hold;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] exp_data;
    int          exp_len;
  } vec_t;

  vec_t tbl [7];

  mac_dot_seq_if #(.VEC_LEN(VEC_LEN)) bus ();

  mac_dot_seq #(.VEC_LEN(VEC_LEN)) dut (
    .clk       (clk),
    .sclr      (sclr),
    .bus       (bus),
    .mac_ina   (mac_ina),
    .mac_inb   (mac_inb),
    .mac_sclrn (mac_sclrn),
    .mac_out   (acc)
  );

  always #5 clk = ~clk;

  // External 8x8->16 accumulator with active-low synchronous clear.
  always @(posedge clk) begin
    if (!mac_sclrn) acc <= 16'd0;
    else            acc <= acc + ({8'd0, mac_ina} * {8'd0, mac_inb});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_dot(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(va[i]) * int'(vb[i]);
    return 16'(s % 65536);
  endfunction

  // Operand zeroing, result hold stability and result count, checked every cycle.
  logic             m_hs, m_rst, m_hold, m_prev_rv;
  logic [7:0]       m_a, m_b;
  logic [15:0]      m_d;
  logic [CNT_W-1:0] m_l;
  always @(posedge clk) begin
    m_hs      = bus.s_valid && bus.s_ready;
    m_rst     = sclr;
    m_a       = bus.s_a;
    m_b       = bus.s_b;
    m_hold    = bus.r_valid && !bus.r_ready;
    m_prev_rv = bus.r_valid;
    m_d       = bus.r_data;
    m_l       = bus.r_len;
    #1;
    if (mon_en) begin
      chk("mon_ina", mac_ina, (m_hs && !m_rst) ? m_a : 8'd0);
      chk("mon_inb", mac_inb, (m_hs && !m_rst) ? m_b : 8'd0);
      if (m_hold && !m_rst) begin
        chk("hold_valid", bus.r_valid, 1);
        chk("hold_data", bus.r_data, m_d);
        chk("hold_len", bus.r_len, m_l);
      end
      if (!m_prev_rv && bus.r_valid === 1'b1) results_seen++;
    end
  end

  task automatic run_vector(input string name, input int n, input bit use_last, input int gap,
                            input int hold, input logic [15:0] exp_data, input int exp_len);
    int t;
    int lat;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b1;
        bus.s_a     = 8'($urandom);
        bus.s_b     = 8'($urandom);
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_a     = va[i];
      bus.s_b     = vb[i];
      bus.s_last  = use_last && (i == n - 1);
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 20) begin
        tick();
        t++;
      end
      chk({name, "_ready_wait"}, (t < 20), 1);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_a     = 8'd0;
    bus.s_b     = 8'd0;
    lat = 1;
    while (bus.r_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_data"}, bus.r_data, exp_data);
    chk({name, "_len"}, bus.r_len, exp_len);
    chk({name, "_s_ready_out"}, bus.s_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({name, "_held_valid"}, bus.r_valid, 1);
      chk({name, "_held_data"}, bus.r_data, exp_data);
      chk({name, "_held_s_ready"}, bus.s_ready, 0);
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    exp_results++;
    chk({name, "_valid_drop"}, bus.r_valid, 0);
    chk({name, "_clear_s_ready"}, bus.s_ready, 0);
    chk({name, "_clear_sclrn"}, mac_sclrn, 0);
    tick();
    chk({name, "_accum_s_ready"}, bus.s_ready, 1);
  endtask

  initial begin
    int n;
    bit ul;

    tbl[0] = '{"dot4",        4, 1'b0, 0, 0, 32'h07050301, 32'h08060402, 16'd100,   4};
    tbl[1] = '{"last2",       2, 1'b1, 0, 0, 32'h0000140A, 32'h0000050A, 16'd200,   2};
    tbl[2] = '{"after_clear", 4, 1'b0, 0, 0, 32'h02020202, 32'h03030303, 16'd24,    4};
    tbl[3] = '{"gaps",        4, 1'b0, 2, 0, 32'h04040404, 32'h04040404, 16'd64,    4};
    tbl[4] = '{"wrap_hold",   4, 1'b0, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hF804,  4};
    tbl[5] = '{"single",      1, 1'b1, 0, 0, 32'h00000007, 32'h00000009, 16'd63,    1};
    tbl[6] = '{"last_at_cap", 4, 1'b1, 1, 2, 32'h01020304, 32'h05060708, 16'd70,    4};

    sclr        = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a     = 8'd0;
    bus.s_b     = 8'd0;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b0;

    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_sclrn", mac_sclrn, 0);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_r_valid", bus.r_valid, 0);
      if (c < 2) tick();
    end
    sclr = 1'b0;
    tick();
    chk("rel_s_ready", bus.s_ready, 1);
    chk("rel_sclrn", mac_sclrn, 1);
    chk("rel_r_valid", bus.r_valid, 0);
    chk("rel_r_data", bus.r_data, 0);
    chk("rel_r_len", bus.r_len, 0);
    chk("rel_ina", mac_ina, 0);

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        va[i] = tbl[k].a[i*8 +: 8];
        vb[i] = tbl[k].b[i*8 +: 8];
      end
      run_vector(tbl[k].name, tbl[k].n, tbl[k].use_last, tbl[k].gap, tbl[k].hold,
                 tbl[k].exp_data, tbl[k].exp_len);
    end

    // Abort two pairs into a vector; the partial sum must never surface.
    bus.s_valid = 1'b1;
    bus.s_a     = 8'd9;
    bus.s_b     = 8'd9;
    bus.s_last  = 1'b0;
    tick();
    tick();
    bus.s_valid = 1'b0;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("abort_s_ready", bus.s_ready, 0);
    chk("abort_sclrn", mac_sclrn, 0);
    chk("abort_r_valid", bus.r_valid, 0);
    chk("abort_r_data", bus.r_data, 0);
    tick();
    chk("abort_resume", bus.s_ready, 1);
    for (int i = 0; i < VEC_LEN; i++) begin
      va[i] = 8'd1;
      vb[i] = 8'd1;
    end
    run_vector("abort_next", 4, 1'b0, 0, 0, 16'd4, 4);

    for (int v = 0; v < 30; v++) begin
      n  = $urandom_range(1, VEC_LEN);
      ul = (n < VEC_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < VEC_LEN; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
      end
      run_vector("rand", n, ul, $urandom_range(0, 2), $urandom_range(0, 3), ref_dot(n), n);
    end

    tick();
    chk("result_count", results_seen, exp_results);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
